// File: rtl/normal_mode_sequencer_pkg.sv
// Shared constants for the intersection sequencer: light codes, phase codes and time limits.
package normal_mode_sequencer_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [6:0] MAX_TIME = 7'd99;
    localparam logic [6:0] MIN_TIME = 7'd1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1G  = 3'd1,
        L1Y  = 3'd2,
        L2G  = 3'd3,
        L2Y  = 3'd4
    } phase_t;

    // A zero duration would never reach the advance condition, so run it as a single tick.
    function automatic logic [6:0] clamp_one(input logic [6:0] v);
        return (v == 7'd0) ? 7'd1 : v;
    endfunction

endpackage

// File: rtl/normal_mode_sequencer_lane_countdown.sv
// Per-lane seconds counter: load has priority over decrement; satOne holds the count at 1.
module lane_countdown (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] loadValue,
    input  logic       dec,
    input  logic       satOne,
    output logic [6:0] count
);

    logic [6:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 7'd0;
        end else if (load) begin
            r_count <= loadValue;
        end else if (dec && (r_count != 7'd0) && !(satOne && (r_count == 7'd1))) begin
            r_count <= r_count - 7'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/normal_mode_sequencer.sv
// Two-lane run-time light sequencer with per-cycle snapshot of the committed durations.
// Optional build macro TIME_CHECK_EN rejects out-of-range or inconsistent duration sets.
module normal_mode_sequencer
    import normal_mode_sequencer_pkg::*;
#(
    parameter logic [6:0] DEF_GREEN  = 7'd25,
    parameter logic [6:0] DEF_YELLOW = 7'd3,
    parameter logic [6:0] DEF_RED    = 7'd28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [6:0] greenTime,
    input  logic [6:0] yellowTime,
    input  logic [6:0] redTime,
    output logic [2:0] lane1Light,
    output logic [2:0] lane2Light,
    output logic [6:0] timeLane1,
    output logic [6:0] timeLane2,
    output logic [2:0] state,
    output logic       cycleStart
);

    phase_t     r_state;
    phase_t     w_next;
    logic [6:0] r_gSnap, r_ySnap, r_rSnap;
    logic       r_cycleStart;
    logic       w_accept, w_enterL1G;
    logic [6:0] w_gNew, w_yNew, w_rNew;
    logic       w_ld1, w_ld2, w_dec, w_sat1, w_sat2;
    logic [6:0] w_val1, w_val2, w_cnt1, w_cnt2;

`ifdef TIME_CHECK_EN
    assign w_accept = (greenTime >= MIN_TIME + 7'd1) && (yellowTime >= MIN_TIME + 7'd1) &&
                      (greenTime <= MAX_TIME) && (yellowTime <= MAX_TIME) && (redTime <= MAX_TIME) &&
                      ({1'b0, redTime} == ({1'b0, greenTime} + {1'b0, yellowTime}));
`else
    assign w_accept = 1'b1;
`endif

    // Snapshot candidates feed both the snapshot registers and the L1G entry loads.
    assign w_gNew = w_accept ? greenTime  : r_gSnap;
    assign w_yNew = w_accept ? yellowTime : r_ySnap;
    assign w_rNew = w_accept ? redTime    : r_rSnap;

    always_comb begin
        w_next = r_state;
        w_ld1  = 1'b0;
        w_ld2  = 1'b0;
        w_val1 = 7'd0;
        w_val2 = 7'd0;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = L1G;
                L1G:     if (tick && (w_cnt1 == 7'd1)) w_next = L1Y;
                L1Y:     if (tick && (w_cnt1 == 7'd1)) w_next = L2G;
                L2G:     if (tick && (w_cnt2 == 7'd1)) w_next = L2Y;
                L2Y:     if (tick && (w_cnt2 == 7'd1)) w_next = L1G;
                default: w_next = IDLE;
            endcase
        end
        if (w_next != r_state) begin
            case (w_next)
                L1G: begin
                    w_ld1  = 1'b1; w_val1 = clamp_one(w_gNew);
                    w_ld2  = 1'b1; w_val2 = clamp_one(w_rNew);
                end
                L1Y: begin
                    w_ld1  = 1'b1; w_val1 = clamp_one(r_ySnap);
                end
                L2G: begin
                    w_ld2  = 1'b1; w_val2 = clamp_one(r_gSnap);
                    w_ld1  = 1'b1; w_val1 = clamp_one(r_rSnap);
                end
                L2Y: begin
                    w_ld2  = 1'b1; w_val2 = clamp_one(r_ySnap);
                end
                default: begin
                    w_ld1 = 1'b1;
                    w_ld2 = 1'b1;
                end
            endcase
        end
    end

    assign w_enterL1G = (w_next == L1G) && (r_state != L1G);
    assign w_dec      = tick && (r_state != IDLE);
    assign w_sat1     = (r_state == L2G) || (r_state == L2Y);
    assign w_sat2     = (r_state == L1G) || (r_state == L1Y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cycleStart <= 1'b0;
            r_gSnap      <= DEF_GREEN;
            r_ySnap      <= DEF_YELLOW;
            r_rSnap      <= DEF_RED;
        end else begin
            r_state      <= w_next;
            r_cycleStart <= w_enterL1G;
            if (w_enterL1G) begin
                r_gSnap <= w_gNew;
                r_ySnap <= w_yNew;
                r_rSnap <= w_rNew;
            end
        end
    end

    lane_countdown u_lane1 (
        .clk(clk), .reset(reset), .load(w_ld1), .loadValue(w_val1),
        .dec(w_dec), .satOne(w_sat1), .count(w_cnt1)
    );

    lane_countdown u_lane2 (
        .clk(clk), .reset(reset), .load(w_ld2), .loadValue(w_val2),
        .dec(w_dec), .satOne(w_sat2), .count(w_cnt2)
    );

    always_comb begin
        lane1Light = LIGHT_RED;
        lane2Light = LIGHT_RED;
        case (r_state)
            L1G:     lane1Light = LIGHT_GREEN;
            L1Y:     lane1Light = LIGHT_YELLOW;
            L2G:     lane2Light = LIGHT_GREEN;
            L2Y:     lane2Light = LIGHT_YELLOW;
            default: ;
        endcase
    end

    assign timeLane1  = w_cnt1;
    assign timeLane2  = w_cnt2;
    assign state      = r_state;
    assign cycleStart = r_cycleStart;

endmodule

// File: tb/tb_normal_mode_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random run against a model.
module tb_normal_mode_sequencer;
    import normal_mode_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [6:0] greenTime, yellowTime, redTime;
    logic [2:0] lane1Light, lane2Light;
    logic [6:0] timeLane1, timeLane2;
    logic [2:0] state;
    logic       cycleStart;

    int checks   = 0;
    int failures = 0;

    normal_mode_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .greenTime(greenTime), .yellowTime(yellowTime), .redTime(redTime),
        .lane1Light(lane1Light), .lane2Light(lane2Light),
        .timeLane1(timeLane1), .timeLane2(timeLane2),
        .state(state), .cycleStart(cycleStart)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int en; int tk; int g; int y; int r;
        int st; int t1; int t2; int l1; int l2; int cs;
    } vec_t;

    localparam int R = 4, Y = 2, G = 1;
    vec_t tbl [21];

    // Behavioural reference: phase, snapshot, per-lane load value and ticks elapsed since that load.
    int m_ph, m_sg, m_sy, m_sr, m_L1, m_L2, m_e1, m_e2, m_cs;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int mdisp(input int L, input int e);
        return (m_ph == 0) ? 0 : max1(L - e);
    endfunction

    function automatic int mlight(input int ph, input int lane);
        if (lane == 1) return (ph == 1) ? G : (ph == 2) ? Y : R;
        return (ph == 3) ? G : (ph == 4) ? Y : R;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_sg = 25; m_sy = 3; m_sr = 28;
        m_L1 = 0; m_L2 = 0; m_e1 = 0; m_e2 = 0; m_cs = 0;
    endtask

    task automatic model_enter(input int p, input int g, input int y, input int r);
        bit ok;
        m_ph = p;
        case (p)
            1: begin
                ok = 1'b1;
`ifdef TIME_CHECK_EN
                if (g < MIN_TIME + 1 || y < MIN_TIME + 1) ok = 1'b0;
                if (g > MAX_TIME || y > MAX_TIME || r > MAX_TIME) ok = 1'b0;
                if (r != g + y) ok = 1'b0;
`endif
                if (ok) begin m_sg = g; m_sy = y; m_sr = r; end
                m_L1 = max1(m_sg); m_L2 = max1(m_sr); m_e1 = 0; m_e2 = 0; m_cs = 1;
            end
            2: begin m_L1 = max1(m_sy); m_e1 = 0; end
            3: begin m_L2 = max1(m_sg); m_L1 = max1(m_sr); m_e1 = 0; m_e2 = 0; end
            default: begin m_L2 = max1(m_sy); m_e2 = 0; end
        endcase
    endtask

    task automatic model_edge(input int en, input int tk, input int g, input int y, input int r);
        int act;
        m_cs = 0;
        if (en == 0) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            model_enter(1, g, y, r);
        end else begin
            act = (m_ph <= 2) ? mdisp(m_L1, m_e1) : mdisp(m_L2, m_e2);
            if (tk != 0) begin m_e1++; m_e2++; end
            if (tk != 0 && act == 1) model_enter((m_ph == 4) ? 1 : m_ph + 1, g, y, r);
        end
    endtask

    task automatic cycle(input int en, input int tk);
        enable = en[0];
        tick   = tk[0];
        @(posedge clk);
        #1;
        tick   = 1'b0;
    endtask

    initial begin
        int en, tk, g, y, r;
        bit seen;

        tbl[0]  = '{1,1,5,2,7, 1,5,7,G,R,1};
        tbl[1]  = '{1,1,5,2,7, 1,4,6,G,R,0};
        tbl[2]  = '{1,1,5,2,7, 1,3,5,G,R,0};
        tbl[3]  = '{1,0,5,2,7, 1,3,5,G,R,0};
        tbl[4]  = '{1,1,5,2,7, 1,2,4,G,R,0};
        tbl[5]  = '{1,1,5,2,7, 1,1,3,G,R,0};
        tbl[6]  = '{1,1,5,2,7, 2,2,2,Y,R,0};
        tbl[7]  = '{1,1,5,2,7, 2,1,1,Y,R,0};
        tbl[8]  = '{1,1,5,2,7, 3,7,5,R,G,0};
        tbl[9]  = '{1,1,3,2,5, 3,6,4,R,G,0};
        tbl[10] = '{1,1,3,2,5, 3,5,3,R,G,0};
        tbl[11] = '{1,1,3,2,5, 3,4,2,R,G,0};
        tbl[12] = '{1,1,3,2,5, 3,3,1,R,G,0};
        tbl[13] = '{1,1,3,2,5, 4,2,2,R,Y,0};
        tbl[14] = '{1,1,3,2,5, 4,1,1,R,Y,0};
        tbl[15] = '{1,1,3,2,5, 1,3,5,G,R,1};
        tbl[16] = '{1,1,3,2,5, 1,2,4,G,R,0};
        tbl[17] = '{1,1,3,2,5, 1,1,3,G,R,0};
        tbl[18] = '{1,1,3,2,5, 2,2,2,Y,R,0};
        tbl[19] = '{0,0,3,2,5, 0,0,0,R,R,0};
        tbl[20] = '{1,1,5,2,7, 1,5,7,G,R,1};

        reset = 1'b1; enable = 1'b0; tick = 1'b0;
        greenTime = 7'd5; yellowTime = 7'd2; redTime = 7'd7;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_state", int'(state), 0);
        chk("reset_l1", int'(lane1Light), R);
        chk("reset_l2", int'(lane2Light), R);
        chk("reset_t1", int'(timeLane1), 0);
        chk("reset_t2", int'(timeLane2), 0);
        chk("reset_cs", int'(cycleStart), 0);

        for (int i = 0; i < 21; i++) begin
            greenTime = 7'(tbl[i].g); yellowTime = 7'(tbl[i].y); redTime = 7'(tbl[i].r);
            cycle(tbl[i].en, tbl[i].tk);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d_t1", i), int'(timeLane1), tbl[i].t1);
            chk($sformatf("tbl%0d_t2", i), int'(timeLane2), tbl[i].t2);
            chk($sformatf("tbl%0d_l1", i), int'(lane1Light), tbl[i].l1);
            chk($sformatf("tbl%0d_l2", i), int'(lane2Light), tbl[i].l2);
            chk($sformatf("tbl%0d_cs", i), int'(cycleStart), tbl[i].cs);
        end

        // Red/green+yellow mismatch: red lane saturates at 1, or the set is rejected in favour of 5/2/7.
        cycle(0, 0);
        greenTime = 7'd5; yellowTime = 7'd2; redTime = 7'd4;
        cycle(1, 0);
        chk("mis_cs", int'(cycleStart), 1);
`ifdef TIME_CHECK_EN
        chk("mis_t2_load", int'(timeLane2), 7);
        repeat (3) cycle(1, 1);
        chk("mis_t2_3", int'(timeLane2), 4);
        cycle(1, 1);
        chk("mis_t2_4", int'(timeLane2), 3);
`else
        chk("mis_t2_load", int'(timeLane2), 4);
        repeat (3) cycle(1, 1);
        chk("mis_t2_3", int'(timeLane2), 1);
        cycle(1, 1);
        chk("mis_t2_4", int'(timeLane2), 1);
`endif
        chk("mis_t1_4", int'(timeLane1), 1);

        // Asynchronous reset in the middle of L2G.
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cycle(1, 1);
            if (state == 3'd3) seen = 1'b1;
        end
        chk("reach_L2G", int'(seen), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_l1", int'(lane1Light), R);
        chk("async_l2", int'(lane2Light), R);
        chk("async_t1", int'(timeLane1), 0);
        chk("async_t2", int'(timeLane2), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        enable = 1'b0;

        // Random run against the model.
        model_reset();
        g = 5; y = 2; r = 7;
        for (int n = 0; n < 4000; n++) begin
            en = ($urandom_range(0, 299) != 0) ? 1 : 0;
            tk = ($urandom_range(0, 2) == 0) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    g = $urandom_range(0, 127); y = $urandom_range(0, 127); r = $urandom_range(0, 127);
                end else begin
                    g = $urandom_range(0, 12); y = $urandom_range(0, 6);
                    r = ($urandom_range(0, 1) == 0) ? g + y : $urandom_range(0, 20);
                end
            end
            greenTime = 7'(g); yellowTime = 7'(y); redTime = 7'(r);
            cycle(en, tk);
            model_edge(en, tk, g, y, r);
            chk("rnd_state", int'(state), m_ph);
            chk("rnd_t1", int'(timeLane1), mdisp(m_L1, m_e1));
            chk("rnd_t2", int'(timeLane2), mdisp(m_L2, m_e2));
            chk("rnd_l1", int'(lane1Light), mlight(m_ph, 1));
            chk("rnd_l2", int'(lane2Light), mlight(m_ph, 2));
            chk("rnd_cs", int'(cycleStart), m_cs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
